// File: rtl/bin_div_pkg.sv
// Shared definitions for the bin_div restoring divider.
//   DW            dividend / quotient width
//   VW            divisor / remainder width
//   CW            iteration counter width (holds 0..DW)
//   state_e       FSM state encoding
//   DIV0_QUOTIENT quotient reported for a zero divisor
package bin_div_pkg;

  localparam int DW = 13;
  localparam int VW = 7;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [DW-1:0] DIV0_QUOTIENT = {DW{1'b1}};

endpackage

// File: rtl/bin_div_step.sv
// One restoring-division step (combinational).
//   r_i      partial remainder (low VW bits; the MSB is always 0 between steps)
//   q_msb_i  next dividend bit shifted into the remainder
//   d_i      divisor
//   r_o      next partial remainder (VW+1 bits)
//   qbit_o   quotient bit produced by this step
module bin_div_step
  import bin_div_pkg::*;
(
  input  logic [VW-1:0] r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          qbit_o
);

  logic [VW:0] r_sh;
  logic [VW:0] trial;

  assign r_sh  = {r_i, q_msb_i};
  assign trial = r_sh - {1'b0, d_i};

  // A borrow (MSB set) means the divisor did not fit: restore the shifted value.
  assign qbit_o = ~trial[VW];
  assign r_o    = trial[VW] ? r_sh : trial;

endmodule

// File: rtl/bin_div.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        load operands and begin (aborts a running division)
//   dividend     DW-bit unsigned dividend, sampled with start
//   divisor      VW-bit unsigned divisor, sampled with start
//   busy         high while iterating
//   done         result valid; held until next start or rst
//   quotient     DW-bit quotient (updated only on entry to FIN)
//   remainder    VW-bit remainder (updated only on entry to FIN)
//   div_by_zero  set together with done when the divisor was zero
module bin_div
  import bin_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [DW-1:0] q_q,     q_d;
  logic [VW-1:0] d_q,     d_d;
  logic [VW:0]   r_q,     r_d;
  logic [DW-1:0] quot_q,  quot_d;
  logic [VW-1:0] rem_q,   rem_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          dbz_q,   dbz_d;

  logic [VW:0]   step_r;
  logic          step_qbit;

  bin_div_step u_step (
    .r_i     (r_q[VW-1:0]),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .qbit_o  (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;

    case (state_q)
      RUN: begin
        if (d_q == '0) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          quot_d  = DIV0_QUOTIENT;
          rem_d   = '0;
        end else begin
          r_d   = step_r;
          q_d   = {q_q[DW-2:0], step_qbit};
          cnt_d = cnt_q + 1'b1;
          // Last step: publish the result including this step's bit.
          if (cnt_q == CW'(DW - 1)) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = {q_q[DW-2:0], step_qbit};
            rem_d   = step_r[VW-1:0];
          end
        end
      end
      default: ;
    endcase

    // start wins over any in-flight iteration (abort and restart).
    if (start) begin
      state_d = RUN;
      q_d     = dividend;
      d_d     = divisor;
      r_d     = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // The partial remainder always stays below the divisor, so its MSB is spare.
  a_r_msb_clear : assert property (@(posedge clk) disable iff (rst) !r_q[VW]);

endmodule

// File: tb/tb_bin_div.sv
module tb_bin_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] dividend;
  logic [6:0]  divisor;
  logic        busy;
  logic        done;
  logic [12:0] quotient;
  logic [6:0]  remainder;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  bin_div dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_q"},    32'(quotient), 0);
    chk({tag, "_r"},    32'(remainder), 0);
    chk({tag, "_dbz"},  32'(div_by_zero), 0);
  endtask

  // Pulse start for one edge (E0); returns right after E0.
  task automatic kick(input logic [12:0] dvd, input logic [6:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Called right after the start edge: count edges until done, check result.
  task automatic wait_result(input string tag, input int exp_q, input int exp_r);
    int n = 0;
    int nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    chk({tag, "_lat"},  n, 13);
    chk({tag, "_busyc"}, nbusy, 13);
    chk({tag, "_q"},    32'(quotient), 32'(exp_q));
    chk({tag, "_r"},    32'(remainder), 32'(exp_r));
    chk({tag, "_dbz"},  32'(div_by_zero), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic        any_nz;
    logic [12:0] a;
    logic [12:0] b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    tick(); tick();
    rst = 1'b0;
    check_zero("rst");
    any_nz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_nz = any_nz | busy | done | div_by_zero | (|quotient) | (|remainder);
    end
    chk("idle20", 32'(any_nz), 0);

    kick(13'd2016, 7'd63);
    chk("s1_busy_e0", 32'(busy), 1);
    wait_result("d2016_63", 32, 0);

    // FIN holds its result while start stays low.
    tick(); tick(); tick();
    chk("fin_done", 32'(done), 1);
    chk("fin_q",    32'(quotient), 32);

    kick(13'd100, 7'd7);   wait_result("d100_7", 14, 2);
    kick(13'd5, 7'd127);   wait_result("d5_127", 0, 5);
    kick(13'd8191, 7'd1);  wait_result("d8191_1", 8191, 0);

    kick(13'd500, 7'd0);
    chk("dz_e0_done", 32'(done), 0);
    tick();
    chk("dz_done", 32'(done), 1);
    chk("dz_flag", 32'(div_by_zero), 1);
    chk("dz_q",    32'(quotient), 8191);
    chk("dz_r",    32'(remainder), 0);
    chk("dz_busy", 32'(busy), 0);

    kick(13'd500, 7'd4);
    chk("dz_clr",  32'(div_by_zero), 0);
    chk("q_hold",  32'(quotient), 8191);
    wait_result("d500_4", 125, 0);

    // Abort: restart at the 5th RUN edge.
    kick(13'd100, 7'd7);
    tick(); tick(); tick(); tick();
    kick(13'd50, 7'd3);
    wait_result("abort_50_3", 16, 2);

    // Reset mid-run at the 6th RUN edge.
    kick(13'd100, 7'd7);
    tick(); tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rst_mid");
    tick();
    chk("rst_mid_idle", 32'(busy | done), 0);

    // Chained with the multiplier: dividend is the product a*b.
    a = 13'd9;
    b = 13'd11;
    kick(a * b, 7'd11);
    wait_result("chain_99_11", 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
